// File: rtl/timer_pkg.sv
// Shared types and constant helpers for the BCD timer datapath.
// Used by bcd_digit and bcd_mod_counter.
package timer_pkg;

    localparam int MAX_DIGITS = 6;
    localparam int MAX_W      = 4 * MAX_DIGITS;

    typedef logic [3:0] bcd_nibble_t;

    // Builds the packed-BCD image of a small integer, digit 0 in the low nibble.
    // Nibbles above 'digits' are left at zero.
    function automatic logic [MAX_W-1:0] to_bcd(input int value, input int digits);
        logic [MAX_W-1:0] res;
        int               v;
        res = '0;
        v   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                res[4*i +: 4] = 4'(v % 10);
                v             = v / 10;
            end
        end
        return res;
    endfunction

    // Every nibble must be a decimal digit and the value must not exceed max_bcd.
    // With both operands in valid BCD, the packed unsigned compare orders them
    // exactly like their decimal values.
    function automatic logic bcd_valid(input logic [MAX_W-1:0] value,
                                       input logic [MAX_W-1:0] max_bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        if (value > max_bcd) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit step: increment or decrement when cin is set,
// with carry/borrow out on the 9->0 or 0->9 roll.
import timer_pkg::*;

module bcd_digit (
    input  bcd_nibble_t d,
    input  logic        up,
    input  logic        cin,
    output bcd_nibble_t q,
    output logic        cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULO up/down packed-BCD counter with combinational terminal count.
// Parallel load is built only when CNT_LOAD_EN is defined.
import timer_pkg::*;

module bcd_mod_counter #(
    parameter int DIGITS = 2,
    parameter int MODULO = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int             W       = 4 * DIGITS;
    localparam logic [W-1:0]   MAX_BCD = W'(to_bcd(MODULO - 1, DIGITS));

    logic [DIGITS:0] carry;
    logic [W-1:0]    step_val;
    logic            at_max;
    logic            at_zero;
    logic            at_end;
    logic [W-1:0]    count_p0;
    logic            wrap_p0;
    logic            load_err_p0;
    logic            unused_bits;

    // Digit ripple: digit 0 always steps, higher digits step on carry/borrow.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .d    (count[4*i +: 4]),
            .up   (up),
            .cin  (carry[i]),
            .q    (step_val[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);
    assign at_end  = up ? at_max : at_zero;

`ifdef CNT_LOAD_EN
    logic load_ok;

    assign load_ok     = bcd_valid(MAX_W'(load_val), MAX_W'(MAX_BCD));
    assign tc          = en & ~clr & ~load & at_end;
    assign unused_bits = carry[DIGITS];
`else
    assign tc          = en & ~clr & at_end;
    assign unused_bits = &{1'b0, carry[DIGITS], load, load_val};
`endif

    // Next-state selection, priority clr > load > en > hold.
    always_comb begin
        count_p0    = count;
        wrap_p0     = 1'b0;
        load_err_p0 = 1'b0;
        if (clr) begin
            count_p0 = '0;
`ifdef CNT_LOAD_EN
        end else if (load) begin
            if (load_ok) begin
                count_p0 = load_val;
            end else begin
                load_err_p0 = 1'b1;
            end
`endif
        end else if (en) begin
            if (at_end) begin
                count_p0 = up ? '0 : MAX_BCD;
                wrap_p0  = 1'b1;
            end else begin
                count_p0 = step_val;
            end
        end
    end

    // Stage boundary: count and status pulses register together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_p0;
            wrap  <= wrap_p0;
        end
    end

`ifdef CNT_LOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_err_p0;
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed self-checking bench: mod-100 and mod-60 counters plus a sec->min cascade.
module tb_bcd_mod_counter;

    logic clk;
    logic reset;

    logic       en_a, up_a, clr_a, load_a;
    logic [7:0] lv_a, count_a;
    logic       tc_a, wrap_a, lerr_a;

    logic       en_b, up_b, clr_b, load_b;
    logic [7:0] lv_b, count_b;
    logic       tc_b, wrap_b, lerr_b;

    logic       en_s;
    logic [7:0] count_s, count_m;
    logic       tc_s, wrap_s, lerr_s, tc_m, wrap_m, lerr_m;

    int errors = 0;
    int checks = 0;
    int mwraps = 0;
    int swraps = 0;

    bcd_mod_counter #(.DIGITS(2), .MODULO(100)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .up(up_a), .clr(clr_a),
        .load(load_a), .load_val(lv_a), .count(count_a), .tc(tc_a),
        .wrap(wrap_a), .load_err(lerr_a));

    bcd_mod_counter #(.DIGITS(2), .MODULO(60)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .up(up_b), .clr(clr_b),
        .load(load_b), .load_val(lv_b), .count(count_b), .tc(tc_b),
        .wrap(wrap_b), .load_err(lerr_b));

    bcd_mod_counter #(.DIGITS(2), .MODULO(60)) u_sec (
        .clk(clk), .reset(reset), .en(en_s), .up(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(8'h00), .count(count_s), .tc(tc_s),
        .wrap(wrap_s), .load_err(lerr_s));

    bcd_mod_counter #(.DIGITS(2), .MODULO(60)) u_min (
        .clk(clk), .reset(reset), .en(tc_s), .up(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(8'h00), .count(count_m), .tc(tc_m),
        .wrap(wrap_m), .load_err(lerr_m));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        en_a = 0; up_a = 1; clr_a = 0; load_a = 0; lv_a = 8'h00;
        en_b = 0; up_b = 1; clr_b = 0; load_b = 0; lv_b = 8'h00;
        en_s = 0;
        #12;
        chk("rst_count_a", count_a, 8'h00);
        chk("rst_wrap_a", wrap_a, 1'b0);
        chk("rst_lerr_a", lerr_a, 1'b0);
        chk("rst_count_b", count_b, 8'h00);
        reset = 1'b1;
        tick();
        chk("hold_idle", count_a, 8'h00);

        // mod-100 up to terminal count and wrap
        en_a = 1; up_a = 1;
        repeat (99) tick();
        chk("a99_count", count_a, 8'h99);
        chk("a99_tc", tc_a, 1'b1);
        chk("a99_wrap", wrap_a, 1'b0);
        tick();
        chk("a_wrap_count", count_a, 8'h00);
        chk("a_wrap_pulse", wrap_a, 1'b1);
        en_a = 0;
        tick();
        chk("a_wrap_end", wrap_a, 1'b0);
        chk("a_hold", count_a, 8'h00);

        // mod-60 down from zero
        en_b = 1; up_b = 0;
        #1;
        chk("b_tc_down0", tc_b, 1'b1);
        tick();
        chk("b_down_count", count_b, 8'h59);
        chk("b_down_wrap", wrap_b, 1'b1);
        chk("b_tc_59_down", tc_b, 1'b0);
        tick();
        chk("b_58_count", count_b, 8'h58);
        chk("b_58_wrap", wrap_b, 1'b0);

        // direction changes take effect on the next edge
        up_b = 1;
        tick();
        chk("b_up59", count_b, 8'h59);
        chk("b_tc_59_up", tc_b, 1'b1);
        up_b = 0;
        tick();
        chk("b_dn58", count_b, 8'h58);
        up_b = 1;
        tick();
        tick();
        chk("b_upwrap_count", count_b, 8'h00);
        chk("b_upwrap_pulse", wrap_b, 1'b1);
        en_b = 0;

`ifdef CNT_LOAD_EN
        load_b = 1; lv_b = 8'h45;
        tick();
        chk("ld45_count", count_b, 8'h45);
        chk("ld45_err", lerr_b, 1'b0);
        lv_b = 8'h60;
        tick();
        chk("ld60_count", count_b, 8'h45);
        chk("ld60_err", lerr_b, 1'b1);
        lv_b = 8'h3A; en_b = 1;
        #1;
        chk("ld_tc_masked", tc_b, 1'b0);
        tick();
        chk("ld3A_count", count_b, 8'h45);
        chk("ld3A_err", lerr_b, 1'b1);
        load_b = 0; en_b = 0;
        tick();
        chk("ld_err_end", lerr_b, 1'b0);
        chk("ld_hold", count_b, 8'h45);
`else
        load_b = 1; lv_b = 8'h45;
        tick();
        chk("ldoff_hold", count_b, 8'h00);
        chk("ldoff_err", lerr_b, 1'b0);
        en_b = 1; up_b = 1;
        tick();
        chk("ldoff_step", count_b, 8'h01);
        chk("ldoff_err2", lerr_b, 1'b0);
        load_b = 0; en_b = 0;
`endif

        // simultaneous clr/load/en at 37
        en_a = 1; up_a = 1;
        repeat (37) tick();
        chk("a37", count_a, 8'h37);
        clr_a = 1; load_a = 1; lv_a = 8'h12;
        tick();
        chk("clr_count", count_a, 8'h00);
        chk("clr_wrap", wrap_a, 1'b0);
        chk("clr_lerr", lerr_a, 1'b0);
        clr_a = 0; load_a = 0; up_a = 0;
        #1;
        chk("a_tc_down0", tc_a, 1'b1);
        clr_a = 1;
        #1;
        chk("a_tc_clr_mask", tc_a, 1'b0);
        tick();
        chk("clr_at_end_count", count_a, 8'h00);
        chk("clr_at_end_wrap", wrap_a, 1'b0);
        clr_a = 0; up_a = 1;

        // asynchronous reset mid-count
        repeat (42) tick();
        chk("a42", count_a, 8'h42);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", count_a, 8'h00);
        tick();
        tick();
        chk("rst_held", count_a, 8'h00);
        #2;
        reset = 1'b1;
        tick();
        chk("rst_resume", count_a, 8'h01);
        en_a = 0;

        // seconds -> minutes cascade over one hour
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        chk("casc_start", {count_m, count_s}, 16'h0000);
        en_s = 1;
        for (int i = 1; i <= 3600; i++) begin
            tick();
            if (wrap_m) mwraps++;
            if (wrap_s) swraps++;
            if (i == 59) chk("casc_tc59", tc_s, 1'b1);
            if (i == 60) chk("casc_60", {count_m, count_s}, 16'h0100);
        end
        chk("casc_3600", {count_m, count_s}, 16'h0000);
        chk("casc_min_wraps", mwraps, 1);
        chk("casc_sec_wraps", swraps, 60);
        en_s = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
